// File: rtl/tiny_proc_pkg.sv
// Shared types and frame geometry for the tiny core loader/arbiter.
package tiny_proc_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int FRAME_W = DATA_W + ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT,
    WAIT_CS
  } ld_state_e;

  typedef enum logic {
    TGT_I,
    TGT_D
  } ld_tgt_e;

endpackage

// File: rtl/ld_frame_shifter.sv
// Serial frame shift register with bit counter; MSB-first, first bit ends up on top.
// Optional LD_ARBITER_PARITY_EN adds an even-parity check over the full frame.
module ld_frame_shifter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int LEN    = DATA_W + ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic              frame_done,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] addr
`ifdef LD_ARBITER_PARITY_EN
  ,
  output logic              parity_ok
`endif
);

  localparam int CW = $clog2(LEN + 1);

  logic [LEN-1:0] sr;
  logic [CW-1:0]  cnt;

  // clr together with en restarts the frame with din as its first bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= en ? LEN'(din) : '0;
      cnt <= en ? CW'(1) : '0;
    end else if (en) begin
      sr  <= {sr[LEN-2:0], din};
      cnt <= cnt + 1'b1;
    end
  end

  // high while the next shifted bit is the last one of the frame
  assign frame_done = (cnt == CW'(LEN - 1));
  assign data       = sr[LEN-1 -: DATA_W];
  assign addr       = sr[LEN-1-DATA_W -: ADDR_W];

`ifdef LD_ARBITER_PARITY_EN
  assign parity_ok = ~^sr;
`endif

endmodule

// File: rtl/ld_arbiter.sv
// SPI program/data loader, core run gating and dcache write-port arbiter.
// Define LD_ARBITER_PARITY_EN to append and check an even-parity bit per frame.
module ld_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csi_n,
  input  logic              csd_n,
  input  logic              mosi,
  input  logic              run_en,
  input  logic              proc_dwen,
  input  logic [ADDR_W-1:0] proc_daddr,
  input  logic [DATA_W-1:0] proc_ddata,
  output logic              core_run,
  output logic              imem_wen,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              dmem_wen,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              frame_err,
  output logic [CNT_W-1:0]  load_cnt
);
  import tiny_proc_pkg::*;

`ifdef LD_ARBITER_PARITY_EN
  localparam int FLEN = DATA_W + ADDR_W + 1;
`else
  localparam int FLEN = DATA_W + ADDR_W;
`endif

  ld_state_e state, state_nxt;
  ld_tgt_e   tgt, tgt_nxt;

  logic              sh_clr, sh_en, frame_done, par_ok;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_iwen, ld_dwen, err_set, cs_sel, st_win, run_rise;

  ld_frame_shifter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .LEN   (FLEN)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (sh_clr),
    .en        (sh_en),
    .din       (mosi),
    .frame_done(frame_done),
    .data      (ld_data),
    .addr      (ld_addr)
`ifdef LD_ARBITER_PARITY_EN
    ,
    .parity_ok (par_ok)
`endif
  );

`ifndef LD_ARBITER_PARITY_EN
  assign par_ok = 1'b1;
`endif

  assign cs_sel = (tgt == TGT_D) ? csd_n : csi_n;
  assign st_win = core_run & proc_dwen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tgt   <= TGT_I;
    end else begin
      state <= state_nxt;
      tgt   <= tgt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    sh_clr    = 1'b0;
    sh_en     = 1'b0;
    ld_iwen   = 1'b0;
    ld_dwen   = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!csi_n && !csd_n) begin
          err_set = 1'b1;
        end else if (!csi_n || !csd_n) begin
          tgt_nxt   = csd_n ? TGT_I : TGT_D;
          sh_clr    = 1'b1;
          sh_en     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_sel) begin
          err_set   = 1'b1;
          sh_clr    = 1'b1;
          state_nxt = IDLE;
        end else begin
          sh_en = 1'b1;
          if (frame_done) state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        // a core store owns the dcache port; the loader waits without bound
        if (tgt == TGT_D && st_win) begin
          state_nxt = COMMIT;
        end else begin
          state_nxt = WAIT_CS;
          if (!par_ok)              err_set = 1'b1;
          else if (tgt == TGT_D)    ld_dwen = 1'b1;
          else if (core_run)        err_set = 1'b1;
          else                      ld_iwen = 1'b1;
        end
      end
      WAIT_CS: begin
        if (csi_n && csd_n) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_wen   = ld_iwen;
  assign imem_addr  = ld_iwen ? ld_addr : '0;
  assign imem_wdata = ld_iwen ? ld_data : '0;

  always_comb begin
    dmem_wen   = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    if (st_win) begin
      dmem_wen   = 1'b1;
      dmem_addr  = proc_daddr;
      dmem_wdata = proc_ddata;
    end else if (ld_dwen) begin
      dmem_wen   = 1'b1;
      dmem_addr  = ld_addr;
      dmem_wdata = ld_data;
    end
  end

  // run requests only take effect with the loader idle; drops are immediate
  assign run_rise = run_en & (state == IDLE) & ~core_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_run  <= 1'b0;
      frame_err <= 1'b0;
      load_cnt  <= '0;
    end else begin
      if (!run_en)              core_run <= 1'b0;
      else if (state == IDLE)   core_run <= 1'b1;
      if (err_set)              frame_err <= 1'b1;
      else if (run_rise)        frame_err <= 1'b0;
      if (ld_iwen || ld_dwen)   load_cnt <= load_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ld_arbiter.sv
// Directed self-checking bench for ld_arbiter (default and LD_ARBITER_PARITY_EN builds).
module tb_ld_arbiter;

`ifdef LD_ARBITER_PARITY_EN
  localparam int FLEN = 13;
`else
  localparam int FLEN = 12;
`endif

  logic       clk = 1'b0;
  logic       rst_n, csi_n, csd_n, mosi, run_en, proc_dwen;
  logic [3:0] proc_daddr;
  logic [7:0] proc_ddata;
  logic       core_run, imem_wen, dmem_wen, frame_err;
  logic [3:0] imem_addr, dmem_addr;
  logic [7:0] imem_wdata, dmem_wdata, load_cnt;

  int checks = 0;
  int failures = 0;
  logic [7:0] ecnt;

  ld_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .csi_n     (csi_n),
    .csd_n     (csd_n),
    .mosi      (mosi),
    .run_en    (run_en),
    .proc_dwen (proc_dwen),
    .proc_daddr(proc_daddr),
    .proc_ddata(proc_ddata),
    .core_run  (core_run),
    .imem_wen  (imem_wen),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .dmem_wen  (dmem_wen),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .frame_err (frame_err),
    .load_cnt  (load_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    csi_n = 1'b1;
    csd_n = 1'b1;
    mosi  = 1'b0;
    repeat (n) tick();
  endtask

  // sends frame bits [from, to) MSB first; frame = data, addr, (parity)
  task automatic send(input logic d, input logic [7:0] dat, input logic [3:0] adr,
                      input int from, input int to, input logic pflip);
    logic [12:0] f;
    f = {dat, adr, (^{dat, adr}) ^ pflip};
    for (int i = from; i < to; i++) begin
      if (d) csd_n = 1'b0;
      else   csi_n = 1'b0;
      mosi = f[12-i];
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; csi_n = 1'b1; csd_n = 1'b1; mosi = 1'b0;
    run_en = 1'b0; proc_dwen = 1'b0; proc_daddr = '0; proc_ddata = '0;
    ecnt = '0;
    #3;
    chk("rst_core_run", core_run, 0);
    chk("rst_imem_wen", imem_wen, 0);
    chk("rst_dmem_wen", dmem_wen, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_load_cnt", load_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // reset in the middle of a frame
    send(1'b0, 8'hA5, 4'h3, 0, 5, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midrst_imem_wen", imem_wen, 0);
    chk("midrst_imem_addr", imem_addr, 0);
    chk("midrst_imem_wdata", imem_wdata, 0);
    chk("midrst_load_cnt", load_cnt, 0);
    csi_n = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("midrst_no_strobe", imem_wen, 0);
    end
    chk("midrst_cnt_after", load_cnt, 0);

    // icache frame A5 @ 3
    send(1'b0, 8'hA5, 4'h3, 0, FLEN, 1'b0);
    chk("i_wen", imem_wen, 1);
    chk("i_addr", imem_addr, 4'h3);
    chk("i_data", imem_wdata, 8'hA5);
    chk("i_dwen", dmem_wen, 0);
    idle(1);
    ecnt++;
    chk("i_wen_drop", imem_wen, 0);
    chk("i_cnt", load_cnt, ecnt);
    idle(1);

    // aborted dcache frame, then a good one
    send(1'b1, 8'hFF, 4'hF, 0, 7, 1'b0);
    chk("abort_dwen", dmem_wen, 0);
    chk("abort_err_pre", frame_err, 0);
    idle(1);
    chk("abort_err", frame_err, 1);
    chk("abort_dwen2", dmem_wen, 0);
    chk("abort_cnt", load_cnt, ecnt);
    send(1'b1, 8'h3C, 4'hE, 0, FLEN, 1'b0);
    chk("d_wen", dmem_wen, 1);
    chk("d_addr", dmem_addr, 4'hE);
    chk("d_data", dmem_wdata, 8'h3C);
    chk("d_iwen", imem_wen, 0);
    idle(1);
    ecnt++;
    chk("d_cnt", load_cnt, ecnt);
    chk("d_wen_drop", dmem_wen, 0);
    idle(1);

    // run the core; the rise clears frame_err
    run_en = 1'b1;
    tick();
    chk("run_up", core_run, 1);
    chk("run_clr_err", frame_err, 0);

    // core store collides with loader commit
    send(1'b1, 8'h11, 4'h2, 0, FLEN, 1'b0);
    proc_dwen = 1'b1; proc_daddr = 4'h5; proc_ddata = 8'h77;
    #1;
    chk("arb1_wen", dmem_wen, 1);
    chk("arb1_addr", dmem_addr, 4'h5);
    chk("arb1_data", dmem_wdata, 8'h77);
    tick();
    chk("arb2_addr", dmem_addr, 4'h5);
    chk("arb2_data", dmem_wdata, 8'h77);
    chk("arb2_cnt", load_cnt, ecnt);
    proc_dwen = 1'b0;
    #1;
    chk("arb3_wen", dmem_wen, 1);
    chk("arb3_addr", dmem_addr, 4'h2);
    chk("arb3_data", dmem_wdata, 8'h11);
    idle(1);
    ecnt++;
    chk("arb_cnt", load_cnt, ecnt);
    chk("arb_wen_drop", dmem_wen, 0);
    idle(1);

    // icache frame while running is refused
    send(1'b0, 8'h5A, 4'h9, 0, FLEN, 1'b0);
    chk("irun_wen", imem_wen, 0);
    idle(1);
    chk("irun_err", frame_err, 1);
    chk("irun_cnt", load_cnt, ecnt);
    run_en = 1'b0;
    tick();
    chk("run_down", core_run, 0);
    chk("run_down_err", frame_err, 1);
    run_en = 1'b1;
    tick();
    chk("run_up2", core_run, 1);
    chk("run_up2_err", frame_err, 0);

`ifdef LD_ARBITER_PARITY_EN
    send(1'b1, 8'hC3, 4'h6, 0, FLEN, 1'b1);
    chk("par_bad_wen", dmem_wen, 0);
    idle(1);
    chk("par_bad_err", frame_err, 1);
    chk("par_bad_cnt", load_cnt, ecnt);
    idle(1);
    send(1'b1, 8'hC3, 4'h6, 0, FLEN, 1'b0);
    chk("par_ok_wen", dmem_wen, 1);
    chk("par_ok_addr", dmem_addr, 4'h6);
    chk("par_ok_data", dmem_wdata, 8'hC3);
    idle(1);
    ecnt++;
    chk("par_ok_cnt", load_cnt, ecnt);
    idle(1);
`endif

    // stop; core store ignored while stopped; run request deferred mid-frame
    run_en = 1'b0;
    tick();
    chk("stop", core_run, 0);
    proc_dwen = 1'b1; proc_daddr = 4'h1; proc_ddata = 8'h01;
    #1;
    chk("store_ignored", dmem_wen, 0);
    proc_dwen = 1'b0;
    send(1'b0, 8'h42, 4'h7, 0, 3, 1'b0);
    run_en = 1'b1;
    send(1'b0, 8'h42, 4'h7, 3, FLEN, 1'b0);
    chk("defer_run", core_run, 0);
    chk("defer_wen", imem_wen, 1);
    chk("defer_addr", imem_addr, 4'h7);
    chk("defer_data", imem_wdata, 8'h42);
    idle(1);
    ecnt++;
    chk("defer_run_wait", core_run, 0);
    chk("defer_cnt", load_cnt, ecnt);
    idle(1);
    chk("defer_run_idle", core_run, 0);
    tick();
    chk("defer_run_up", core_run, 1);
    run_en = 1'b0;
    tick();
    chk("defer_run_down", core_run, 0);

    // load counter wrap
    while (ecnt != 8'hFF) begin
      send(1'b0, ecnt, ecnt[3:0], 0, FLEN, 1'b0);
      idle(2);
      ecnt++;
    end
    chk("cnt_max", load_cnt, 8'hFF);
    send(1'b0, 8'h00, 4'h0, 0, FLEN, 1'b0);
    idle(2);
    ecnt++;
    chk("cnt_wrap", load_cnt, ecnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
